// File: rtl/aes_gcm_pkg.sv
// Shared definitions for the AES-GCM pipeline: phase codes, block width,
// the pipeline latency and the GCM 32-bit counter increment.
package aes_gcm_pkg;

   localparam int BLK_W            = 128;
   localparam int GCM_PIPE_LATENCY = 11;

   typedef enum logic [2:0] {
      PH_NOP  = 3'd0,
      PH_HKEY = 3'd1,
      PH_J0   = 3'd2,
      PH_AAD  = 3'd3,
      PH_TEXT = 3'd4,
      PH_LEN  = 3'd5
   } phase_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HKEY,
      ST_J0,
      ST_AAD,
      ST_TEXT,
      ST_LEN,
      ST_DRAIN
   } state_t;

   // GCM inc32: only the rightmost 32 bits count, wrapping mod 2^32.
   function automatic logic [BLK_W-1:0] inc32(input logic [BLK_W-1:0] b);
      return {b[BLK_W-1:32], b[31:0] + 32'd1};
   endfunction

endpackage

// File: rtl/aes_gcm_phase_scheduler.sv
// Issues one AES-GCM pipeline slot per cycle for a job (HKEY, J0, AAD, TEXT,
// LEN), inserting NOP bubbles when input data is missing, then drains.
module aes_gcm_phase_scheduler
   import aes_gcm_pkg::*;
#(
   parameter int PIPE_LATENCY = GCM_PIPE_LATENCY,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [BLK_W-1:0]  i_j0,
   input  logic [CNT_W-1:0]  i_aad_blocks,
   input  logic [CNT_W-1:0]  i_pt_blocks,
   input  logic              i_data_valid,
   input  logic [BLK_W-1:0]  i_data,
   output logic              o_data_ready,
   output logic [2:0]        o_phase,
   output logic [BLK_W-1:0]  o_block,
   output logic [BLK_W-1:0]  o_cb,
   output logic [BLK_W-1:0]  o_instance_size,
   output logic              o_busy,
   output logic              o_done,
   output state_t            o_dbg_state
);

   localparam int DW = $clog2(PIPE_LATENCY + 1);

   state_t           state;
   logic [BLK_W-1:0] j0;
   logic [BLK_W-1:0] cb;
   logic [CNT_W-1:0] aad_rem;
   logic [CNT_W-1:0] pt_rem;
   logic [DW-1:0]    drain_cnt;

   // Handshake: a data block transfers on a rising edge where both
   // i_data_valid and o_data_ready are high; there is no other transfer.
   // Ready depends on state only, so the source may see it before deciding.
   assign o_data_ready = (state == ST_AAD) || (state == ST_TEXT);
   assign o_dbg_state  = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         j0              <= '0;
         cb              <= '0;
         aad_rem         <= '0;
         pt_rem          <= '0;
         drain_cnt       <= '0;
         o_phase         <= PH_NOP;
         o_block         <= '0;
         o_cb            <= '0;
         o_instance_size <= '0;
         o_busy          <= 1'b0;
         o_done          <= 1'b0;
      end else begin
         o_done  <= 1'b0;
         o_phase <= PH_NOP;
         o_block <= '0;
         o_cb    <= '0;
         case (state)
            ST_IDLE: begin
               // A start landing on the done pulse is dropped on purpose.
               if (i_start && !o_done) begin
                  j0              <= i_j0;
                  aad_rem         <= i_aad_blocks;
                  pt_rem          <= i_pt_blocks;
                  o_instance_size <= {64'(i_aad_blocks) << 7, 64'(i_pt_blocks) << 7};
                  cb              <= inc32(i_j0);
                  o_busy          <= 1'b1;
                  state           <= ST_HKEY;
               end
            end
            ST_HKEY: begin
               o_phase <= PH_HKEY;
               state   <= ST_J0;
            end
            ST_J0: begin
               o_phase <= PH_J0;
               o_cb    <= j0;
               if (aad_rem != '0)     state <= ST_AAD;
               else if (pt_rem != '0) state <= ST_TEXT;
               else                   state <= ST_LEN;
            end
            ST_AAD: begin
               if (i_data_valid) begin
                  o_phase <= PH_AAD;
                  o_block <= i_data;
                  aad_rem <= aad_rem - CNT_W'(1);
                  if (aad_rem == CNT_W'(1))
                     state <= (pt_rem != '0) ? ST_TEXT : ST_LEN;
               end
            end
            ST_TEXT: begin
               if (i_data_valid) begin
                  o_phase <= PH_TEXT;
                  o_block <= i_data;
                  o_cb    <= cb;
                  cb      <= inc32(cb);
                  pt_rem  <= pt_rem - CNT_W'(1);
                  if (pt_rem == CNT_W'(1)) state <= ST_LEN;
               end
            end
            ST_LEN: begin
               o_phase   <= PH_LEN;
               o_block   <= o_instance_size;
               // Loaded one short so done lands PIPE_LATENCY cycles after the LEN slot.
               drain_cnt <= DW'(PIPE_LATENCY - 1);
               state     <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (drain_cnt == '0) begin
                  o_done <= 1'b1;
                  o_busy <= 1'b0;
                  state  <= ST_IDLE;
               end else begin
                  drain_cnt <= drain_cnt - DW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_gcm_phase_scheduler.sv
// Directed bench for aes_gcm_phase_scheduler with hand-computed slot lists.
module tb_aes_gcm_phase_scheduler;
   import aes_gcm_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_start;
   logic [127:0] i_j0;
   logic [15:0]  i_aad_blocks;
   logic [15:0]  i_pt_blocks;
   logic         i_data_valid;
   logic [127:0] i_data;
   logic         o_data_ready;
   logic [2:0]   o_phase;
   logic [127:0] o_block;
   logic [127:0] o_cb;
   logic [127:0] o_instance_size;
   logic         o_busy;
   logic         o_done;
   state_t       o_dbg_state;

   aes_gcm_phase_scheduler #(.PIPE_LATENCY(11), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_j0(i_j0),
      .i_aad_blocks(i_aad_blocks), .i_pt_blocks(i_pt_blocks),
      .i_data_valid(i_data_valid), .i_data(i_data),
      .o_data_ready(o_data_ready), .o_phase(o_phase), .o_block(o_block),
      .o_cb(o_cb), .o_instance_size(o_instance_size), .o_busy(o_busy),
      .o_done(o_done), .o_dbg_state(o_dbg_state)
   );

   // clock
   initial forever #5 clk = ~clk;

   typedef struct {
      logic [2:0]   ph;
      logic [127:0] blk;
      logic [127:0] cb;
      int           cyc;
   } slot_t;

   slot_t        slot_q[$];
   int           done_q[$];
   logic [2:0]   exp_ph_q[$];
   logic [127:0] exp_blk_q[$];
   logic [127:0] exp_cb_q[$];
   bit           exp_blkchk_q[$];
   bit           exp_cbchk_q[$];

   int  errors = 0;
   int  checks = 0;
   int  cyc = 0;
   int  didx = 0;
   bit  ready_s = 0, valid_s = 0, ready_seen = 0;
   bit  use_pat = 0, poke_busy = 0, start_on_done = 0, clr_start = 0;
   int  pk = 0;
   bit  pat [5] = '{1, 0, 0, 1, 1};

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [127:0] mk(input int idx);
      return {96'hD0D0D0D0_11111111_22222222, 32'(idx)};
   endfunction

   // monitor: one record per cycle, sampled mid-cycle
   initial forever begin
      @(negedge clk);
      cyc++;
      slot_q.push_back('{o_phase, o_block, o_cb, cyc});
      if (o_done) done_q.push_back(cyc);
      if (o_data_ready) ready_seen = 1;
      ready_s = o_data_ready;
      valid_s = i_data_valid;
      if (start_on_done && o_done) begin
         i_start       = 1'b1;
         clr_start     = 1;
         start_on_done = 0;
      end
   end

   // data source driver
   initial forever begin
      @(posedge clk);
      #1;
      if (clr_start) begin
         i_start   = 1'b0;
         clr_start = 0;
      end
      if (poke_busy && o_dbg_state == ST_TEXT) begin
         i_start   = 1'b1;
         clr_start = 1;
         poke_busy = 0;
      end
      if (ready_s && valid_s) didx++;
      i_data = mk(didx);
      if (use_pat && o_data_ready && pk < 5) begin
         i_data_valid = pat[pk];
         pk++;
      end else begin
         i_data_valid = 1'b1;
      end
   end

   task automatic exp_push(input logic [2:0] ph, input logic [127:0] blk, input bit bchk,
                           input logic [127:0] cbv, input bit cchk);
      exp_ph_q.push_back(ph);
      exp_blk_q.push_back(blk);
      exp_blkchk_q.push_back(bchk);
      exp_cb_q.push_back(cbv);
      exp_cbchk_q.push_back(cchk);
   endtask

   task automatic exp_clear();
      exp_ph_q.delete(); exp_blk_q.delete(); exp_cb_q.delete();
      exp_blkchk_q.delete(); exp_cbchk_q.delete();
   endtask

   task automatic start_job(input logic [127:0] j0, input logic [15:0] aad, input logic [15:0] pt);
      @(posedge clk);
      #2;
      slot_q.delete();
      done_q.delete();
      ready_seen   = 0;
      pk           = 0;
      didx         = 0;
      i_j0         = j0;
      i_aad_blocks = aad;
      i_pt_blocks  = pt;
      i_start      = 1'b1;
      @(posedge clk);
      #2;
      i_start = 1'b0;
   endtask

   task automatic run_job(input logic [127:0] j0, input logic [15:0] aad, input logic [15:0] pt);
      int n;
      start_job(j0, aad, pt);
      n = 0;
      while (done_q.size() == 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (done_q.size() == 0) check("done_timeout", 0, 1);
      repeat (5) @(negedge clk);
   endtask

   // scoreboard: compare issued non-NOP slots against the expected queues
   task automatic check_slots(input string tag, input logic [127:0] isize);
      slot_t act[$];
      int    len_cyc;
      len_cyc = -1;
      foreach (slot_q[i])
         if (slot_q[i].ph != PH_NOP) act.push_back(slot_q[i]);
      check($sformatf("%s_slot_count", tag), act.size(), exp_ph_q.size());
      for (int i = 0; i < act.size() && i < exp_ph_q.size(); i++) begin
         check($sformatf("%s_ph%0d", tag, i), act[i].ph, exp_ph_q[i]);
         if (exp_blkchk_q[i]) check($sformatf("%s_blk%0d", tag, i), act[i].blk, exp_blk_q[i]);
         if (exp_cbchk_q[i])  check($sformatf("%s_cb%0d", tag, i), act[i].cb, exp_cb_q[i]);
         if (act[i].ph == PH_LEN) len_cyc = act[i].cyc;
      end
      check($sformatf("%s_done_pulses", tag), done_q.size(), 1);
      if (done_q.size() > 0 && len_cyc >= 0)
         check($sformatf("%s_done_latency", tag), done_q[0] - len_cyc, 11);
      check($sformatf("%s_isize", tag), o_instance_size, isize);
      check($sformatf("%s_idle_busy", tag), o_busy, 0);
   endtask

   localparam logic [127:0] J0_B = 128'h00112233_44556677_8899AABB_00000001;
   localparam logic [127:0] J0_G = 128'h11111111_22222222_33333333_00000010;
   localparam logic [127:0] J0_W = 128'hCAFEBABE_DEADBEEF_01234567_FFFFFFFE;

   task automatic expect_basic();
      exp_clear();
      exp_push(PH_HKEY, 128'd0, 1, 128'd0, 1);
      exp_push(PH_J0,   128'd0, 0, J0_B, 1);
      exp_push(PH_AAD,  mk(0), 1, 128'd0, 0);
      exp_push(PH_TEXT, mk(1), 1, 128'h00112233_44556677_8899AABB_00000002, 1);
      exp_push(PH_TEXT, mk(2), 1, 128'h00112233_44556677_8899AABB_00000003, 1);
      exp_push(PH_LEN,  {64'd128, 64'd256}, 1, 128'd0, 0);
   endtask

   initial begin
      int first_text;
      int n;
      logic [2:0] seq [5];
      rst_n = 1'b0; i_start = 1'b0; i_j0 = '0; i_aad_blocks = '0; i_pt_blocks = '0;
      i_data_valid = 1'b0; i_data = '0;
      repeat (3) @(negedge clk);
      check("rst_phase", o_phase, PH_NOP);
      check("rst_block", o_block, 0);
      check("rst_cb", o_cb, 0);
      check("rst_isize", o_instance_size, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_ready", o_data_ready, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // basic job
      expect_basic();
      run_job(J0_B, 16'd1, 16'd2);
      check_slots("basic", {64'd128, 64'd256});

      // empty job
      exp_clear();
      exp_push(PH_HKEY, 128'd0, 1, 128'd0, 1);
      exp_push(PH_J0,   128'd0, 0, J0_B, 1);
      exp_push(PH_LEN,  128'd0, 1, 128'd0, 0);
      run_job(J0_B, 16'd0, 16'd0);
      check_slots("empty", 128'd0);
      check("empty_ready_seen", ready_seen, 0);

      // valid gaps
      use_pat = 1;
      exp_clear();
      exp_push(PH_HKEY, 128'd0, 1, 128'd0, 1);
      exp_push(PH_J0,   128'd0, 0, J0_G, 1);
      exp_push(PH_TEXT, mk(0), 1, 128'h11111111_22222222_33333333_00000011, 1);
      exp_push(PH_TEXT, mk(1), 1, 128'h11111111_22222222_33333333_00000012, 1);
      exp_push(PH_TEXT, mk(2), 1, 128'h11111111_22222222_33333333_00000013, 1);
      exp_push(PH_LEN,  {64'd0, 64'd384}, 1, 128'd0, 0);
      run_job(J0_G, 16'd0, 16'd3);
      use_pat = 0;
      check_slots("gaps", {64'd0, 64'd384});
      seq = '{PH_TEXT, PH_NOP, PH_NOP, PH_TEXT, PH_TEXT};
      first_text = -1;
      foreach (slot_q[i])
         if (first_text < 0 && slot_q[i].ph == PH_TEXT) first_text = i;
      check("gaps_text_found", first_text >= 0, 1);
      if (first_text >= 0)
         for (int k = 0; k < 5 && first_text + k < slot_q.size(); k++)
            check($sformatf("gaps_seq%0d", k), slot_q[first_text + k].ph, seq[k]);

      // counter wrap
      exp_clear();
      exp_push(PH_HKEY, 128'd0, 1, 128'd0, 1);
      exp_push(PH_J0,   128'd0, 0, J0_W, 1);
      exp_push(PH_TEXT, mk(0), 1, 128'hCAFEBABE_DEADBEEF_01234567_FFFFFFFF, 1);
      exp_push(PH_TEXT, mk(1), 1, 128'hCAFEBABE_DEADBEEF_01234567_00000000, 1);
      exp_push(PH_TEXT, mk(2), 1, 128'hCAFEBABE_DEADBEEF_01234567_00000001, 1);
      exp_push(PH_LEN,  {64'd0, 64'd384}, 1, 128'd0, 0);
      run_job(J0_W, 16'd0, 16'd3);
      check_slots("wrap", {64'd0, 64'd384});

      // start while busy, plus a start coinciding with done
      expect_basic();
      poke_busy     = 1;
      start_on_done = 1;
      run_job(J0_B, 16'd1, 16'd2);
      check_slots("busy", {64'd128, 64'd256});
      check("busy_poke_fired", poke_busy, 0);
      check("busy_state_idle", o_dbg_state, ST_IDLE);
      poke_busy = 0;
      start_on_done = 0;

      // reset mid-job during AAD
      start_job(J0_B, 16'd3, 16'd1);
      n = 0;
      while (!(o_dbg_state == ST_AAD && o_phase == PH_AAD) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("mid_reach_aad", o_phase, PH_AAD);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_phase", o_phase, PH_NOP);
      check("mid_rst_block", o_block, 0);
      check("mid_rst_isize", o_instance_size, 0);
      check("mid_rst_busy", o_busy, 0);
      check("mid_rst_ready", o_data_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      expect_basic();
      run_job(J0_B, 16'd1, 16'd2);
      check_slots("after_rst", {64'd128, 64'd256});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
